// File: rtl/instruction_queue_pkg.sv
// Shared ISA field widths and field-position helpers for the fetch queue,
// decoder and control FSM.
package instruction_queue_pkg;

  localparam int unsigned OPCODE_W_DEF = 4;
  localparam int unsigned REG_W_DEF    = 5;
  localparam int unsigned IMM_W_DEF    = 8;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned DEPTH_DEF    = 4;

  // Field MSB positions for the default ISA layout: op | rd | rs1 | rs2 | imm
  localparam int unsigned IMM_MSB = IMM_W_DEF - 1;
  localparam int unsigned RS2_MSB = IMM_W_DEF + REG_W_DEF - 1;
  localparam int unsigned RS1_MSB = IMM_W_DEF + 2 * REG_W_DEF - 1;
  localparam int unsigned RD_MSB  = IMM_W_DEF + 3 * REG_W_DEF - 1;
  localparam int unsigned OP_MSB  = RD_MSB + OPCODE_W_DEF;

  function automatic int unsigned instr_width(int unsigned opcode_w, int unsigned reg_w,
                                              int unsigned imm_w);
    return opcode_w + 3 * reg_w + imm_w;
  endfunction

  // LSB of a register field: slot 0 = rs2, 1 = rs1, 2 = rd, 3 = opcode
  function automatic int unsigned field_lsb(int unsigned imm_w, int unsigned reg_w,
                                            int unsigned slot);
    return imm_w + slot * reg_w;
  endfunction

endpackage

// File: rtl/instruction_field_decode.sv
// Splits the queue head into opcode/register/immediate fields; all outputs read
// zero while no head entry is present.
module instruction_field_decode
  import instruction_queue_pkg::*;
#(
  parameter  int unsigned OPCODE_W = OPCODE_W_DEF,
  parameter  int unsigned REG_W    = REG_W_DEF,
  parameter  int unsigned IMM_W    = IMM_W_DEF,
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  localparam int unsigned INSTR_W  = instr_width(OPCODE_W, REG_W, IMM_W)
) (
  input  logic                valid,
  input  logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    reg_dest,
  output logic [REG_W-1:0]    reg_source_1,
  output logic [REG_W-1:0]    reg_source_2,
  output logic [IMM_W-1:0]    immediate,
  output logic [DATA_W-1:0]   imm_sext
);

  localparam int unsigned RS2_LSB = field_lsb(IMM_W, REG_W, 0);
  localparam int unsigned RS1_LSB = field_lsb(IMM_W, REG_W, 1);
  localparam int unsigned RD_LSB  = field_lsb(IMM_W, REG_W, 2);
  localparam int unsigned OP_LSB  = field_lsb(IMM_W, REG_W, 3);

  always_comb begin
    opcode       = '0;
    reg_dest     = '0;
    reg_source_1 = '0;
    reg_source_2 = '0;
    immediate    = '0;
    imm_sext     = '0;
    if (valid) begin
      opcode       = instr[OP_LSB +: OPCODE_W];
      reg_dest     = instr[RD_LSB +: REG_W];
      reg_source_1 = instr[RS1_LSB +: REG_W];
      reg_source_2 = instr[RS2_LSB +: REG_W];
      immediate    = instr[IMM_W-1:0];
      imm_sext     = DATA_W'($signed(instr[IMM_W-1:0]));
    end
  end

endmodule

// File: rtl/instruction_queue.sv
// DEPTH-entry FIFO of fetched instructions between memory fetch and the
// multicycle control unit, with valid/ready on both sides and a synchronous flush.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter  int unsigned OPCODE_W = OPCODE_W_DEF,
  parameter  int unsigned REG_W    = REG_W_DEF,
  parameter  int unsigned IMM_W    = IMM_W_DEF,
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  localparam int unsigned INSTR_W  = instr_width(OPCODE_W, REG_W, IMM_W),
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instruction_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    reg_dest,
  output logic [REG_W-1:0]    reg_source_1,
  output logic [REG_W-1:0]    reg_source_2,
  output logic [IMM_W-1:0]    immediate,
  output logic [DATA_W-1:0]   imm_sext,
  output logic [CNT_W-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_nxt;
  logic               push;
  logic               pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Flags are registered from the next count so they track count exactly.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      in_ready  <= (count_nxt != CNT_W'(DEPTH));
      out_valid <= (count_nxt != CNT_W'(0));
    end
  end

  // Storage needs no reset; a voided push never lands.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem[wr_ptr] <= instruction_in;
    end
  end

  instruction_field_decode #(
    .OPCODE_W (OPCODE_W),
    .REG_W    (REG_W),
    .IMM_W    (IMM_W),
    .DATA_W   (DATA_W)
  ) u_decode (
    .valid        (out_valid),
    .instr        (mem[rd_ptr]),
    .opcode       (opcode),
    .reg_dest     (reg_dest),
    .reg_source_1 (reg_source_1),
    .reg_source_2 (reg_source_2),
    .immediate    (immediate),
    .imm_sext     (imm_sext)
  );

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: default instance plus a DEPTH=8/IMM_W=6 instance,
// each checked every cycle against a queue-based model.
module tb_instruction_queue;

  localparam int unsigned DA   = 4;
  localparam int unsigned DB   = 8;
  localparam int unsigned IMMA = 8;
  localparam int unsigned IMMB = 6;

  logic clk = 1'b0;
  logic reset, flush;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [26:0] instr_a;
  logic [3:0]  op_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [7:0]  imm_a;
  logic [15:0] sext_a;
  logic [2:0]  count_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [24:0] instr_b;
  logic [3:0]  op_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [5:0]  imm_b;
  logic [15:0] sext_b;
  logic [3:0]  count_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  longint qa[$];
  longint qb[$];

  always #5 clk = ~clk;

  instruction_queue u_dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .instruction_in(instr_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .opcode(op_a), .reg_dest(rd_a), .reg_source_1(rs1_a), .reg_source_2(rs2_a),
    .immediate(imm_a), .imm_sext(sext_a), .count(count_a)
  );

  instruction_queue #(.IMM_W(IMMB), .DEPTH(DB)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .instruction_in(instr_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .opcode(op_b), .reg_dest(rd_b), .reg_source_1(rs1_b), .reg_source_2(rs2_b),
    .immediate(imm_b), .imm_sext(sext_b), .count(count_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fld(input longint w, input int lsb, input int width);
    return (w >> lsb) & ((longint'(1) << width) - 1);
  endfunction

  function automatic longint sext(input longint w, input int immw, input int dataw);
    longint v;
    v = fld(w, 0, immw);
    if (v >= (longint'(1) << (immw - 1))) v = v - (longint'(1) << immw);
    return v & ((longint'(1) << dataw) - 1);
  endfunction

  // Model: a plain FIFO of words; accept when not full, release head when not empty.
  always @(posedge clk) begin
    bit pa, oa, pb, ob;
    if (reset || flush) begin
      qa.delete();
      qb.delete();
    end else begin
      pa = in_valid_a && (qa.size() != DA);
      oa = out_ready_a && (qa.size() != 0);
      pb = in_valid_b && (qb.size() != DB);
      ob = out_ready_b && (qb.size() != 0);
      if (oa) void'(qa.pop_front());
      if (pa) qa.push_back(longint'(instr_a));
      if (ob) void'(qb.pop_front());
      if (pb) qb.push_back(longint'(instr_b));
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    longint h;
    bit v;
    if (chk_en) begin
      v = (qa.size() != 0);
      h = v ? qa[0] : 0;
      chk("a.count", count_a, qa.size());
      chk("a.in_ready", in_ready_a, qa.size() != DA);
      chk("a.out_valid", out_valid_a, v);
      chk("a.opcode", op_a, v ? fld(h, IMMA + 15, 4) : 0);
      chk("a.reg_dest", rd_a, v ? fld(h, IMMA + 10, 5) : 0);
      chk("a.reg_source_1", rs1_a, v ? fld(h, IMMA + 5, 5) : 0);
      chk("a.reg_source_2", rs2_a, v ? fld(h, IMMA, 5) : 0);
      chk("a.immediate", imm_a, v ? fld(h, 0, IMMA) : 0);
      chk("a.imm_sext", sext_a, v ? sext(h, IMMA, 16) : 0);

      v = (qb.size() != 0);
      h = v ? qb[0] : 0;
      chk("b.count", count_b, qb.size());
      chk("b.in_ready", in_ready_b, qb.size() != DB);
      chk("b.out_valid", out_valid_b, v);
      chk("b.opcode", op_b, v ? fld(h, IMMB + 15, 4) : 0);
      chk("b.reg_dest", rd_b, v ? fld(h, IMMB + 10, 5) : 0);
      chk("b.reg_source_1", rs1_b, v ? fld(h, IMMB + 5, 5) : 0);
      chk("b.reg_source_2", rs2_b, v ? fld(h, IMMB, 5) : 0);
      chk("b.immediate", imm_b, v ? fld(h, 0, IMMB) : 0);
      chk("b.imm_sext", sext_b, v ? sext(h, IMMB, 16) : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; instr_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; instr_b = '0;

    // Reset for two cycles
    step();
    chk_en = 1'b1;
    step();
    chk("rst.count", count_a, 0);
    chk("rst.out_valid", out_valid_a, 0);
    chk("rst.in_ready", in_ready_a, 1);
    chk("rst.opcode", op_a, 0);
    chk("rst.imm_sext", sext_a, 0);
    reset = 1'b0;

    // Single word into empty queue, visible the cycle after the push
    in_valid_a = 1'b1; instr_a = 27'h1800AAA;
    step();
    in_valid_a = 1'b0;
    chk("w1.out_valid", out_valid_a, 1);
    chk("w1.opcode", op_a, 3);
    chk("w1.reg_dest", rd_a, 0);
    chk("w1.reg_source_1", rs1_a, 0);
    chk("w1.reg_source_2", rs2_a, 'hA);
    chk("w1.immediate", imm_a, 'hAA);
    chk("w1.imm_sext", sext_a, 'hFFAA);
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
    chk("w1.drained", count_a, 0);

    // Fill to full, hold a fifth word, then drain in order
    for (int i = 1; i <= 4; i++) begin
      in_valid_a = 1'b1; instr_a = 27'(i * 'h11);
      step();
    end
    chk("full.count", count_a, 4);
    chk("full.in_ready", in_ready_a, 0);
    instr_a = 27'h55;
    step();
    chk("full.hold_count", count_a, 4);
    chk("full.head", imm_a, 'h11);
    out_ready_a = 1'b1;
    step();
    chk("pop1.count", count_a, 3);
    chk("pop1.imm", imm_a, 'h22);
    step();
    in_valid_a = 1'b0;
    chk("pop2.count", count_a, 3);
    chk("pop2.imm", imm_a, 'h33);
    step();
    chk("pop3.imm", imm_a, 'h44);
    step();
    chk("pop4.imm", imm_a, 'h55);
    step();
    chk("pop5.count", count_a, 0);
    out_ready_a = 1'b0;

    // Simultaneous push/pop at count 2, wrapping pointers over 3*DEPTH words
    for (int i = 1; i <= 2; i++) begin
      in_valid_a = 1'b1; instr_a = 27'('h100 + i);
      step();
    end
    out_ready_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      instr_a = 27'('h200 + k);
      step();
      chk("pp.count", count_a, 2);
    end
    in_valid_a = 1'b0;
    chk("pp.head_imm", imm_a, 'h0A);
    chk("pp.head_rs2", rs2_a, 2);
    step();
    step();
    chk("pp.drained", count_a, 0);
    out_ready_a = 1'b0;

    // Flush at count 3 with a concurrent push
    for (int i = 1; i <= 3; i++) begin
      in_valid_a = 1'b1; instr_a = 27'('h300 + i);
      step();
    end
    chk("fl.count3", count_a, 3);
    flush = 1'b1; instr_a = 27'h3FF;
    step();
    flush = 1'b0; in_valid_a = 1'b0;
    chk("fl.count", count_a, 0);
    chk("fl.out_valid", out_valid_a, 0);
    chk("fl.in_ready", in_ready_a, 1);
    out_ready_a = 1'b1;
    step();
    chk("fl.still_empty", out_valid_a, 0);
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; instr_a = 27'h0000123;
    step();
    in_valid_a = 1'b0;
    chk("fl.next_word", imm_a, 'h23);

    // Reset mid-stream drops everything
    in_valid_a = 1'b1; instr_a = 27'h0000456;
    step();
    in_valid_a = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst.count", count_a, 0);
    chk("mid_rst.out_valid", out_valid_a, 0);

    // Random traffic on both instances
    for (int c = 0; c < 1000; c++) begin
      in_valid_a  = 1'($urandom_range(0, 1));
      out_ready_a = 1'($urandom_range(0, 1));
      instr_a     = 27'($urandom);
      in_valid_b  = 1'($urandom_range(0, 1));
      out_ready_b = 1'($urandom_range(0, 1));
      instr_b     = 25'($urandom);
      step();
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("end.count_a", count_a, 0);
    chk("end.count_b", count_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
